// File: rtl/arbiter_mux_pkg.sv
// Shared helpers for the round-robin stream multiplexer.
package arbiter_mux_pkg;

  // Modulo add for operands already below size, so one subtraction is enough.
  function automatic int unsigned wrap_add(int unsigned base, int unsigned ofs, int unsigned size);
    int unsigned s;
    s = base + ofs;
    return (s >= size) ? s - size : s;
  endfunction

endpackage

// File: rtl/arbiter_mux_rr_arbiter.sv
// Round-robin arbiter: rotate the request vector so ptr sits at bit 0, priority-encode,
// then map the offset back to a channel index modulo SIZE.
module rr_arbiter
  import arbiter_mux_pkg::*;
#(
  parameter int SIZE = 8
) (
  input  logic [SIZE-1:0]         valid,
  input  logic [$clog2(SIZE)-1:0] ptr,
  output logic [SIZE-1:0]         grant,
  output logic [$clog2(SIZE)-1:0] index
);

  localparam int SEL_W = $clog2(SIZE);

  logic [SIZE-1:0] rot;
  logic            found;
  int unsigned     pos;

  always_comb begin
    // Doubling the vector makes the rotation valid for any SIZE, not just powers of two.
    rot   = SIZE'({valid, valid} >> ptr);
    found = 1'b0;
    pos   = 0;
    grant = '0;
    index = '0;
    for (int j = 0; j < SIZE; j++) begin
      if (!found && rot[j]) begin
        found = 1'b1;
        pos   = wrap_add(32'(ptr), j, SIZE);
      end
    end
    if (found) begin
      index        = SEL_W'(pos);
      grant[index] = 1'b1;
    end
  end

endmodule

// File: rtl/arbiter_mux.sv
// Round-robin SIZE-to-1 stream mux with a one-entry registered output buffer;
// oSelect tags each word with its source channel.
module arbiter_mux
  import arbiter_mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SIZE  = 8
) (
  input  logic                    iClk,
  input  logic                    iRst_n,
  input  logic [SIZE-1:0]         iValid,
  input  logic [SIZE*WIDTH-1:0]   iData,
  output logic [SIZE-1:0]         oReady,
  output logic                    oValid,
  output logic [WIDTH-1:0]        oData,
  output logic [$clog2(SIZE)-1:0] oSelect,
  input  logic                    iReady
);

  localparam int SEL_W = $clog2(SIZE);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] win_index;
  logic [SIZE-1:0]  grant;
  logic             load;
  logic             take;
  logic [WIDTH-1:0] mux_data;

  rr_arbiter #(.SIZE(SIZE)) u_arb (
    .valid (iValid),
    .ptr   (ptr),
    .grant (grant),
    .index (win_index)
  );

  assign load   = ~oValid | iReady;
  assign oReady = grant & {SIZE{load}};
  assign take   = |oReady;

  always_comb begin
    mux_data = '0;
    for (int i = 0; i < SIZE; i++) begin
      mux_data = mux_data | (iData[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oValid  <= 1'b0;
      oData   <= '0;
      oSelect <= '0;
      ptr     <= '0;
    end else if (take) begin
      oValid  <= 1'b1;
      oData   <= mux_data;
      oSelect <= win_index;
      ptr     <= SEL_W'(wrap_add(32'(win_index), 1, SIZE));
    end else if (iReady) begin
      oValid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_arbiter_mux.sv
// Directed bench for arbiter_mux at WIDTH=8, SIZE=3: vector table plus reset-mid-stall sequence.
module tb_arbiter_mux;

  localparam int WIDTH = 8;
  localparam int SIZE  = 3;

  logic                  iClk;
  logic                  iRst_n;
  logic [SIZE-1:0]       iValid;
  logic [SIZE*WIDTH-1:0] iData;
  logic [SIZE-1:0]       oReady;
  logic                  oValid;
  logic [WIDTH-1:0]      oData;
  logic [1:0]            oSelect;
  logic                  iReady;

  int errors = 0;
  int checks = 0;

  arbiter_mux #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
    .iClk    (iClk),
    .iRst_n  (iRst_n),
    .iValid  (iValid),
    .iData   (iData),
    .oReady  (oReady),
    .oValid  (oValid),
    .oData   (oData),
    .oSelect (oSelect),
    .iReady  (iReady)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  typedef struct {
    logic [2:0]  valid;
    logic        ready;
    logic [23:0] data;
    logic [2:0]  exp_rdy;
    logic        exp_v;
    logic [7:0]  exp_d;
    logic [1:0]  exp_s;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  localparam logic [23:0] D = 24'h33_22_11;

  initial begin
    iRst_n = 1'b0;
    iValid = '0;
    iData  = D;
    iReady = 1'b0;

    // full-load rotation from ptr=0
    vecs.push_back('{3'b111, 1'b1, D, 3'b001, 1'b1, 8'h11, 2'd0});
    vecs.push_back('{3'b111, 1'b1, D, 3'b010, 1'b1, 8'h22, 2'd1});
    vecs.push_back('{3'b111, 1'b1, D, 3'b100, 1'b1, 8'h33, 2'd2});
    vecs.push_back('{3'b111, 1'b1, D, 3'b001, 1'b1, 8'h11, 2'd0});
    vecs.push_back('{3'b111, 1'b1, D, 3'b010, 1'b1, 8'h22, 2'd1});
    // backpressure: 0x22 held for 4 cycles, then channel 2
    for (int k = 0; k < 4; k++)
      vecs.push_back('{3'b111, 1'b0, D, 3'b000, 1'b1, 8'h22, 2'd1});
    vecs.push_back('{3'b111, 1'b1, D, 3'b100, 1'b1, 8'h33, 2'd2});
    // sparse / withdrawn requests, ptr=0 then 1
    vecs.push_back('{3'b001, 1'b1, D, 3'b001, 1'b1, 8'h11, 2'd0});
    vecs.push_back('{3'b001, 1'b1, D, 3'b001, 1'b1, 8'h11, 2'd0});
    vecs.push_back('{3'b101, 1'b1, D, 3'b100, 1'b1, 8'h33, 2'd2});
    // wrap: ptr back at 0, not 3
    vecs.push_back('{3'b011, 1'b1, D, 3'b001, 1'b1, 8'h11, 2'd0});
    // idle drain
    vecs.push_back('{3'b000, 1'b1, D, 3'b000, 1'b0, 8'h00, 2'd0});
    vecs.push_back('{3'b000, 1'b0, D, 3'b000, 1'b0, 8'h00, 2'd0});
    // empty buffer accepts even with downstream stalled
    vecs.push_back('{3'b010, 1'b0, D, 3'b010, 1'b1, 8'h22, 2'd1});
    // single requester, ptr=2, new data every cycle, no bubbles
    for (int k = 0; k < 5; k++)
      vecs.push_back('{3'b010, 1'b1, {8'h33, 8'(8'h40 + k), 8'h11}, 3'b010, 1'b1, 8'(8'h40 + k), 2'd1});
    vecs.push_back('{3'b000, 1'b1, D, 3'b000, 1'b0, 8'h00, 2'd0});

    #2;
    check("reset_ovalid", 32'(oValid), 32'd0);
    check("reset_odata", 32'(oData), 32'd0);
    check("reset_osel", 32'(oSelect), 32'd0);
    @(negedge iClk);
    iRst_n = 1'b1;

    foreach (vecs[n]) begin
      @(negedge iClk);
      iValid = vecs[n].valid;
      iReady = vecs[n].ready;
      iData  = vecs[n].data;
      #1;
      check($sformatf("v%0d_oready", n), 32'(oReady), 32'(vecs[n].exp_rdy));
      @(posedge iClk);
      #1;
      check($sformatf("v%0d_ovalid", n), 32'(oValid), 32'(vecs[n].exp_v));
      if (vecs[n].exp_v) begin
        check($sformatf("v%0d_odata", n), 32'(oData), 32'(vecs[n].exp_d));
        check($sformatf("v%0d_osel", n), 32'(oSelect), 32'(vecs[n].exp_s));
      end
    end

    // reset mid-stall: ptr=2 after the single-requester run, so channel 2 loads
    @(negedge iClk);
    iValid = 3'b111;
    iReady = 1'b0;
    iData  = D;
    @(posedge iClk);
    #1;
    check("stall_load_data", 32'(oData), 32'h33);
    @(negedge iClk);
    check("stall_held_valid", 32'(oValid), 32'd1);
    check("stall_oready", 32'(oReady), 32'd0);
    iRst_n = 1'b0;
    #1;
    check("async_rst_ovalid", 32'(oValid), 32'd0);
    check("async_rst_odata", 32'(oData), 32'd0);
    check("async_rst_osel", 32'(oSelect), 32'd0);
    @(negedge iClk);
    iRst_n = 1'b1;
    iReady = 1'b1;
    #1;
    check("post_rst_oready", 32'(oReady), 32'b001);
    @(posedge iClk);
    #1;
    check("post_rst_odata", 32'(oData), 32'h11);
    check("post_rst_osel", 32'(oSelect), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
